pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WAIT_MAX, default 15: memory-wait cycles tolerated before bus error; legal range 1..255.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 mem_ready  in  1  instruction word valid on bus this cycle.
REQ-005 irq  in  1  level-sensitive interrupt request.
REQ-006 dec_jmp  in  1  decoded instruction is a jump; valid while in DECODE.
REQ-007 dec_halt  in  1  decoded instruction is halt; valid while in DECODE.
REQ-008 dec_multi  in  1  decoded instruction needs multi-cycle execute; valid while in DECODE.
REQ-009 exec_done  in  1  multi-cycle execute finished; valid while in EXEC.
REQ-010 ei / di  in  1 each  enable / disable-interrupt pulses from decoder.
REQ-011 mem_rd  out  1  instruction fetch request.
REQ-012 ir_load  out  1  load instruction register.
REQ-013 pc_incr / pc_ce / pc_vec  out  1 each  drive PC increment, conditional load, jump-to-0xFF00.
REQ-014 exec_en  out  1  datapath execute strobe.
REQ-015 int_ack  out  1  interrupt accepted, one-cycle pulse.
REQ-016 int_en  out  1  current interrupt-enable flag.
REQ-017 bus_err  out  1  fetch timeout, one-cycle pulse.
REQ-018 halted  out  1  high while in HALT.
REQ-019 state  out  3  current state code.
REQ-020 retired  out  16  retired-instruction count.

Function
REQ-021 States SHALL be BOOT=0, FETCH=1, MEMWAIT=2, DECODE=3, EXEC=4, JUMP=5, IRQ=6, HALT=7; state, int_en, wait counter and retired are registers; all other outputs are combinational from state and inputs.
REQ-022 BOOT: pc_vec=1 for one cycle -> FETCH.
REQ-023 FETCH: mem_rd=1; if mem_ready then ir_load=1, pc_incr=1 -> DECODE; else wait counter<=1 -> MEMWAIT.
REQ-024 MEMWAIT: mem_rd=1; if mem_ready then ir_load=1, pc_incr=1 -> DECODE; else if counter==WAIT_MAX then bus_err=1 -> HALT; else counter<=counter+1 and stay.
REQ-025 DECODE priority: dec_halt -> HALT; else dec_jmp -> JUMP; else dec_multi -> EXEC (exec_en=0 in DECODE); else exec_en=1, retire, -> boundary.
REQ-026 EXEC: exec_en=1; on exec_done retire -> boundary; else stay (no timeout).
REQ-027 JUMP: pc_ce=1 for one cycle, retire -> boundary.
REQ-028 Boundary: next state SHALL be IRQ if irq && int_en at that cycle, else FETCH.
REQ-029 IRQ: pc_vec=1, int_ack=1 for one cycle; int_en<=0 -> FETCH.
REQ-030 HALT: halted=1, no other strobes; irq && int_en -> IRQ; else stay until reset.
REQ-031 int_en: ei sets, di clears, di wins when both high; IRQ entry clears and overrides ei in same cycle.
REQ-032 Retire: retired<=retired+1 mod 2^16 (0xFFFF wraps to 0x0000); halt instruction does not retire.
REQ-033 At most one of pc_incr, pc_ce, pc_vec SHALL be high in any cycle.

Reset
REQ-034 rst high SHALL immediately force state=BOOT, int_en=0, wait counter=0, retired=0x0000, independent of clk.
REQ-035 During reset all strobes (mem_rd, ir_load, pc_*, exec_en, int_ack, bus_err, halted) SHALL read 0 except pc_vec, which follows BOOT decode only after rst deasserts.
REQ-036 Reset asserted mid-fetch, mid-exec or in HALT SHALL abandon the operation with no bus_err or int_ack pulse.

Verification
REQ-037 Release reset, mem_ready=1, plain instruction -> states 0,1,3,1; pc_vec cycle 1, ir_load+pc_incr cycle 2, exec_en cycle 3, retired=1.
REQ-038 WAIT_MAX=3, mem_ready held 0 -> FETCH, MEMWAIT x3, bus_err pulse once, state=7, halted=1.
REQ-039 ei pulse, then irq=1 during multi-cycle EXEC -> no entry until exec_done; then IRQ with int_ack+pc_vec one cycle, int_en=0, FETCH.
REQ-040 ei and di same cycle -> int_en=0; irq held -> never enters IRQ.
REQ-041 Preload retired via 65535 instructions, retire one more -> retired=0x0000.
REQ-042 Assert rst during MEMWAIT (count 2) -> state=0 same cycle, no bus_err; restart fetches normally.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bundle between the program-counter sequencer and its decoder/datapath/memory.
// The master modport is the sequencer side; slave is the surrounding datapath.
interface pc_sequencer_if;
  logic        mem_ready;
  logic        irq;
  logic        dec_jmp;
  logic        dec_halt;
  logic        dec_multi;
  logic        exec_done;
  logic        ei;
  logic        di;
  logic        mem_rd;
  logic        ir_load;
  logic        pc_incr;
  logic        pc_ce;
  logic        pc_vec;
  logic        exec_en;
  logic        int_ack;
  logic        int_en;
  logic        bus_err;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] retired;

  modport master (
    input  mem_ready, irq, dec_jmp, dec_halt, dec_multi, exec_done, ei, di,
    output mem_rd, ir_load, pc_incr, pc_ce, pc_vec, exec_en, int_ack,
           int_en, bus_err, halted, state, retired
  );

  modport slave (
    output mem_ready, irq, dec_jmp, dec_halt, dec_multi, exec_done, ei, di,
    input  mem_rd, ir_load, pc_incr, pc_ce, pc_vec, exec_en, int_ack,
           int_en, bus_err, halted, state, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetch/wait/decode/execute/jump control with interrupt
// entry at instruction boundaries, fetch timeout and a retired-instruction counter.
module pc_sequencer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_sequencer_if.master       bus
);

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    FETCH   = 3'd1,
    MEMWAIT = 3'd2,
    DECODE  = 3'd3,
    EXEC    = 3'd4,
    JUMP    = 3'd5,
    IRQ     = 3'd6,
    HALT    = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  state_t      state_r;
  state_t      next_s;
  state_t      boundary_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_next_s;
  logic        int_en_r;
  logic        int_en_next_s;
  logic [15:0] retired_r;
  logic        retire_s;
  logic        mem_rd_s;
  logic        ir_load_s;
  logic        pc_incr_s;
  logic        pc_ce_s;
  logic        pc_vec_s;
  logic        exec_en_s;
  logic        int_ack_s;
  logic        bus_err_s;
  logic        halted_s;

  // Next-state, strobe and interrupt-enable decode from current state and inputs.
  always_comb begin
    next_s     = state_r;
    cnt_next_s = cnt_r;
    retire_s   = 1'b0;
    mem_rd_s   = 1'b0;
    ir_load_s  = 1'b0;
    pc_incr_s  = 1'b0;
    pc_ce_s    = 1'b0;
    pc_vec_s   = 1'b0;
    exec_en_s  = 1'b0;
    int_ack_s  = 1'b0;
    bus_err_s  = 1'b0;
    halted_s   = 1'b0;
    boundary_s = (bus.irq && int_en_r) ? IRQ : FETCH;

    case (state_r)
      BOOT: begin
        pc_vec_s = 1'b1;
        next_s   = FETCH;
      end
      FETCH: begin
        mem_rd_s = 1'b1;
        if (bus.mem_ready) begin
          ir_load_s = 1'b1;
          pc_incr_s = 1'b1;
          next_s    = DECODE;
        end else begin
          cnt_next_s = 8'd1;
          next_s     = MEMWAIT;
        end
      end
      MEMWAIT: begin
        mem_rd_s = 1'b1;
        if (bus.mem_ready) begin
          ir_load_s = 1'b1;
          pc_incr_s = 1'b1;
          next_s    = DECODE;
        end else if (cnt_r == WAIT_LIMIT) begin
          bus_err_s = 1'b1;
          next_s    = HALT;
        end else begin
          cnt_next_s = cnt_r + 8'd1;
        end
      end
      DECODE: begin
        if (bus.dec_halt) begin
          next_s = HALT;
        end else if (bus.dec_jmp) begin
          next_s = JUMP;
        end else if (bus.dec_multi) begin
          next_s = EXEC;
        end else begin
          exec_en_s = 1'b1;
          retire_s  = 1'b1;
          next_s    = boundary_s;
        end
      end
      EXEC: begin
        exec_en_s = 1'b1;
        if (bus.exec_done) begin
          retire_s = 1'b1;
          next_s   = boundary_s;
        end else begin
          next_s = EXEC;
        end
      end
      JUMP: begin
        pc_ce_s  = 1'b1;
        retire_s = 1'b1;
        next_s   = boundary_s;
      end
      IRQ: begin
        pc_vec_s  = 1'b1;
        int_ack_s = 1'b1;
        next_s    = FETCH;
      end
      HALT: begin
        halted_s = 1'b1;
        if (bus.irq && int_en_r) begin
          next_s = IRQ;
        end else begin
          next_s = HALT;
        end
      end
      default: begin
        next_s = BOOT;
      end
    endcase

    // Taking the interrupt must clear the enable even if ei arrives in the same cycle.
    if (state_r == IRQ) begin
      int_en_next_s = 1'b0;
    end else if (bus.di) begin
      int_en_next_s = 1'b0;
    end else if (bus.ei) begin
      int_en_next_s = 1'b1;
    end else begin
      int_en_next_s = int_en_r;
    end
  end

  // State, wait counter, interrupt enable and retire counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= BOOT;
      cnt_r     <= 8'd0;
      int_en_r  <= 1'b0;
      retired_r <= 16'h0000;
    end else begin
      state_r   <= next_s;
      cnt_r     <= cnt_next_s;
      int_en_r  <= int_en_next_s;
      retired_r <= retired_r + {15'd0, retire_s};
    end
  end

  // Strobes are held low for the whole reset window, including BOOT's pc_vec.
  assign bus.mem_rd  = mem_rd_s  & ~rst;
  assign bus.ir_load = ir_load_s & ~rst;
  assign bus.pc_incr = pc_incr_s & ~rst;
  assign bus.pc_ce   = pc_ce_s   & ~rst;
  assign bus.pc_vec  = pc_vec_s  & ~rst;
  assign bus.exec_en = exec_en_s & ~rst;
  assign bus.int_ack = int_ack_s & ~rst;
  assign bus.bus_err = bus_err_s & ~rst;
  assign bus.halted  = halted_s  & ~rst;
  assign bus.int_en  = int_en_r;
  assign bus.state   = state_r;
  assign bus.retired = retired_r;

endmodule
